// File: rtl/lsu_mem_initiator_pkg.sv
// Shared constants, types and default latencies for the load/store memory initiator.
package lsu_mem_initiator_pkg;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b0111;
  localparam logic [3:0] SIGN_BIT  = 4'b1000;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam int unsigned DEFAULT_READ_LATENCY  = 3;
  localparam int unsigned DEFAULT_WRITE_LATENCY = 2;

  localparam int unsigned CNT_W = 8;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StResp,
    StErr
  } state_e;

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// Pipeline request/response and data-memory port bundle for the load/store initiator.
interface lsu_mem_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memread;
  logic        mem_memwrite;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err, stall,
    output mem_addr, mem_write_data, mem_memread, mem_memwrite, mem_sign_mask
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall,
    input  mem_addr, mem_write_data, mem_memread, mem_memwrite, mem_sign_mask
  );
endinterface

// File: rtl/lsu_req_decode.sv
// Decodes funct3 / low address bits / direction into the memory sign_mask and an error flag.
module lsu_req_decode
  import lsu_mem_initiator_pkg::*;
(
  input  logic       we,
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  output logic [3:0] sign_mask,
  output logic       err
);

  always_comb begin
    sign_mask = '0;
    err       = 1'b0;
    case (funct3)
      F3_B:  sign_mask = we ? MASK_BYTE : (MASK_BYTE | SIGN_BIT);
      F3_H: begin
        sign_mask = we ? MASK_HALF : (MASK_HALF | SIGN_BIT);
        err       = addr_lo[0];
      end
      F3_W: begin
        sign_mask = MASK_WORD;
        err       = |addr_lo;
      end
      F3_BU: begin
        sign_mask = MASK_BYTE;
        err       = we;
      end
      F3_HU: begin
        sign_mask = MASK_HALF;
        err       = we | addr_lo[0];
      end
      default: err = 1'b1;
    endcase
    // Errored requests never reach the memory, so keep the mask clean.
    if (err) sign_mask = '0;
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Single-outstanding load/store initiator: one-cycle memory strobe, fixed-latency wait, response.
module lsu_mem_initiator
  import lsu_mem_initiator_pkg::*;
#(
  parameter int unsigned READ_LATENCY  = DEFAULT_READ_LATENCY,
  parameter int unsigned WRITE_LATENCY = DEFAULT_WRITE_LATENCY
) (
  input  logic               clk,
  input  logic               rst_n,
  lsu_mem_initiator_if.master bus
);

  localparam cnt_t RdCnt = cnt_t'(READ_LATENCY);
  localparam cnt_t WrCnt = cnt_t'(WRITE_LATENCY);

  state_e      state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;

  logic [3:0]  dec_mask;
  logic        dec_err;

  lsu_req_decode u_decode (
    .we        (bus.req_we),
    .funct3    (bus.req_funct3),
    .addr_lo   (bus.req_addr[1:0]),
    .sign_mask (dec_mask),
    .err       (dec_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          we_d = bus.req_we;
          if (dec_err) begin
            state_d = StErr;
          end else begin
            // Only good requests update the memory-facing registers so the bus holds
            // its last issued values across an errored request.
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
            mask_d  = dec_mask;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        cnt_d   = we_q ? WrCnt : RdCnt;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q - cnt_t'(1);
        if (cnt_q == cnt_t'(1)) begin
          if (!we_q) rdata_d = bus.mem_read_data;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign bus.req_ready      = (state_q == StIdle);
  assign bus.stall          = (state_q != StIdle);
  assign bus.resp_valid     = (state_q == StResp) || (state_q == StErr);
  assign bus.resp_err       = (state_q == StErr);
  assign bus.resp_rdata     = ((state_q == StResp) && !we_q) ? rdata_q : '0;
  assign bus.mem_memread    = (state_q == StIssue) && !we_q;
  assign bus.mem_memwrite   = (state_q == StIssue) && we_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_write_data = wdata_q;
  assign bus.mem_sign_mask  = mask_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed, table-driven bench for lsu_mem_initiator with a fixed-latency memory model.
module tb_lsu_mem_initiator;

  localparam int READ_LAT = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lsu_mem_initiator_if bus ();

  lsu_mem_initiator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] model;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_mask;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t vecs[10];

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model: read data is valid only in the cycle the initiator should sample it.
  logic [31:0] model_data = 32'h0;
  int          rd_cnt = 0;
  always @(posedge clk) begin
    if (bus.mem_memread) rd_cnt <= READ_LAT;
    else if (rd_cnt != 0) rd_cnt <= rd_cnt - 1;
  end
  assign bus.mem_read_data = (rd_cnt == 1) ? model_data : 32'hBAD0BAD0;

  // Bus monitor
  int          rd_tot = 0;
  int          wr_tot = 0;
  int          resp_tot = 0;
  logic        both_seen = 1'b0;
  logic [3:0]  cap_mask = '0;
  logic [31:0] cap_addr = '0;
  logic [31:0] cap_wdata = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_memread && bus.mem_memwrite) both_seen <= 1'b1;
      if (bus.mem_memread) rd_tot <= rd_tot + 1;
      if (bus.mem_memwrite) wr_tot <= wr_tot + 1;
      if (bus.resp_valid) resp_tot <= resp_tot + 1;
      if (bus.mem_memread || bus.mem_memwrite) begin
        cap_mask  <= bus.mem_sign_mask;
        cap_addr  <= bus.mem_addr;
        cap_wdata <= bus.mem_write_data;
      end
    end
  end

  logic [31:0] last_good_addr = 32'h0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive_req(input logic v, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid  = v;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int   r0, w0, k;
    logic seen, stall_ok;
    @(negedge clk);
    check({name, "_ready"}, 32'(bus.req_ready), 32'd1);
    r0 = rd_tot;
    w0 = wr_tot;
    model_data = v.model;
    drive_req(1'b1, v.we, v.f3, v.addr, v.wdata);
    seen = 1'b0;
    stall_ok = 1'b1;
    k = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (!bus.stall) stall_ok = 1'b0;
      if (k == 1 && !v.exp_err)
        check({name, "_strobe_in_issue"}, 32'(bus.mem_memread | bus.mem_memwrite), 32'd1);
      if (bus.resp_valid) begin
        seen = 1'b1;
        check({name, "_latency"}, 32'(k), 32'(v.exp_lat));
        check({name, "_rdata"}, bus.resp_rdata, v.exp_rdata);
        check({name, "_err"}, 32'(bus.resp_err), 32'(v.exp_err));
      end
      // Spurious requests while busy must be ignored.
      if (!seen && k[0]) drive_req(1'b1, 1'b0, 3'd2, 32'h0000_3000, 32'h0);
      else drive_req(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    end
    check({name, "_resp_seen"}, 32'(seen), 32'd1);
    check({name, "_stall"}, 32'(stall_ok), 32'd1);
    #1;
    check({name, "_rd_pulses"}, 32'(rd_tot - r0), 32'(v.exp_rd));
    check({name, "_wr_pulses"}, 32'(wr_tot - w0), 32'(v.exp_wr));
    if (!v.exp_err) begin
      check({name, "_mask"}, 32'(cap_mask), 32'(v.exp_mask));
      check({name, "_addr"}, cap_addr, v.addr);
      if (v.we) check({name, "_wdata"}, cap_wdata, v.wdata);
      last_good_addr = v.addr;
    end else begin
      check({name, "_addr_hold"}, bus.mem_addr, last_good_addr);
    end
  endtask

  initial begin
    int resp0;
    //        we    f3    addr          wdata         model         exp_rdata     mask     err  lat rd wr
    vecs[0] = '{1'b0, 3'd2, 32'h0000_1004, 32'h0,         32'hDEADBEEF, 32'hDEADBEEF, 4'b0111, 1'b0, 5, 1, 0};
    vecs[1] = '{1'b0, 3'd0, 32'h0000_1001, 32'h0,         32'hFFFFFF80, 32'hFFFFFF80, 4'b1001, 1'b0, 5, 1, 0};
    vecs[2] = '{1'b0, 3'd4, 32'h0000_1001, 32'h0,         32'hFFFFFF80, 32'hFFFFFF80, 4'b0001, 1'b0, 5, 1, 0};
    vecs[3] = '{1'b1, 3'd2, 32'h0000_2000, 32'h0000_0055, 32'h0,        32'h0,        4'b0111, 1'b0, 4, 0, 1};
    vecs[4] = '{1'b0, 3'd2, 32'h0000_1008, 32'h0,         32'h12345678, 32'h12345678, 4'b0111, 1'b0, 5, 1, 0};
    vecs[5] = '{1'b0, 3'd1, 32'h0000_1003, 32'h0,         32'h0,        32'h0,        4'b0000, 1'b1, 1, 0, 0};
    vecs[6] = '{1'b1, 3'd2, 32'h0000_1002, 32'h0000_00AA, 32'h0,        32'h0,        4'b0000, 1'b1, 1, 0, 0};
    vecs[7] = '{1'b0, 3'd3, 32'h0000_1000, 32'h0,         32'h0,        32'h0,        4'b0000, 1'b1, 1, 0, 0};
    vecs[8] = '{1'b1, 3'd1, 32'h0000_1002, 32'h0000_ABCD, 32'h0,        32'h0,        4'b0011, 1'b0, 4, 0, 1};
    vecs[9] = '{1'b0, 3'd5, 32'h0000_1006, 32'h0,         32'h0000F00D, 32'h0000F00D, 4'b0011, 1'b0, 5, 1, 0};

    rst_n = 1'b0;
    drive_req(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_write_data, 32'h0);
    check("rst_strobes", 32'({bus.mem_memread, bus.mem_memwrite}), 32'd0);
    check("rst_mask", 32'(bus.mem_sign_mask), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while a load is in its wait phase.
    @(negedge clk);
    model_data = 32'h11112222;
    drive_req(1'b1, 1'b0, 3'd2, 32'h0000_1010, 32'h0);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    @(negedge clk);
    check("midrst_in_wait", 32'(bus.stall), 32'd1);
    resp0 = resp_tot;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("midrst_stall", 32'(bus.stall), 32'd0);
    check("midrst_ready", 32'(bus.req_ready), 32'd1);
    check("midrst_mem_addr", bus.mem_addr, 32'h0);
    check("midrst_mask", 32'(bus.mem_sign_mask), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_no_resp", 32'(resp_tot), 32'(resp0));
    check("midrst_ready_after", 32'(bus.req_ready), 32'd1);
    last_good_addr = 32'h0;
    run_vec(vecs[0], "post_rst_lw");

    check("strobe_overlap", 32'(both_seen), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
